// File: rtl/alu_seq.sv
// alu_seq
//   Multi-cycle integer ALU. Arithmetic and logic opcodes (0-7) complete in a
//   single step; shifts and rotates (8-F) advance one bit position per clock
//   for count[4:0] steps. Operands are sized to 8, 16 or 32 bits, and results
//   are zero-extended above the operand size.
//
// Ports
//   clock      in   rising-edge system clock
//   reset_n    in   asynchronous active-low reset
//   start      in   one-cycle request, sampled only while idle
//   alu        in   opcode (0 ADD,1 OR,2 ADC,3 SBB,4 AND,5 SUB,6 XOR,7 CMP,
//                   8 ROL,9 ROR,A RCL,B RCR,C/E SHL,D SHR,F SAR)
//   size       in   0 = 8-bit, 1 = 16-bit, 2 = 32-bit (WIDTH=32 only), 3 = 16-bit
//   op1/op2    in   operands (op2 unused by shifts/rotates)
//   count      in   shift/rotate count, low five bits used
//   flags      in   incoming FLAGS (CF=0, PF=2, AF=4, ZF=6, SF=7, OF=11)
//   busy       out  operation in progress (cycle after start through done)
//   done       out  one-cycle completion pulse
//   result     out  registered result, held until the next done
//   flags_out  out  registered FLAGS, held until the next done
//   write      out  result should be written back (0 for CMP and count-0 shifts)

module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       alu,
  input  logic [1:0]       size,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [7:0]       count,
  input  logic [11:0]      flags,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [11:0]      flags_out,
  output logic             write
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_nx;

  logic             accept;
  logic [4:0]       cnt;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] msbm_r;
  logic [WIDTH-1:0] val_r;
  logic             cf_r;
  logic             msb0_r;
  logic [11:0]      flags_r;

  logic [WIDTH-1:0] mask_in;
  logic [WIDTH-1:0] msbm_in;

  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH:0]   cin_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] ar_res;
  logic [11:0]      ar_flags;
  logic             ar_cf;
  logic             ar_af;
  logic             ar_of;
  logic             a_msb;
  logic             b_msb;
  logic             r_msb;
  logic             is_sub;
  logic             is_logic;

  logic [WIDTH-1:0] shl_val;
  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] step_val;
  logic             step_cf;
  logic             v_msb;
  logic             v_lsb;
  logic             s_msb;
  logic             s_msb1;
  logic             sh_of;
  logic [11:0]      sh_flags;

  logic             unused_bits;

  assign unused_bits = ^count[7:5];

  assign accept = (state == IDLE) && start;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  // Operand-size mask and its MSB one-hot. A 32-bit request on a 16-bit
  // build, and the reserved code 3, both fall back to 16 bits.
  always_comb begin
    mask_in = ~({WIDTH{1'b1}} << 16);
    if (size == 2'd0) begin
      mask_in = ~({WIDTH{1'b1}} << 8);
    end else if ((size == 2'd2) && (WIDTH == 32)) begin
      mask_in = '1;
    end
    msbm_in = mask_in ^ (mask_in >> 1);
  end

  // Single-step arithmetic/logic on the sized inputs. The adder is one bit
  // wider than the datapath so the carry/borrow out of the sized MSB is the
  // bit just above it, picked out with the MSB one-hot shifted up by one.
  always_comb begin
    a_in     = op1 & mask_in;
    b_in     = op2 & mask_in;
    cin_ext  = {{WIDTH{1'b0}}, flags[0]};
    sum      = '0;
    is_sub   = 1'b0;
    is_logic = 1'b0;
    case (alu[2:0])
      3'd0: sum = {1'b0, a_in} + {1'b0, b_in};
      3'd1: begin sum = {1'b0, a_in | b_in}; is_logic = 1'b1; end
      3'd2: sum = {1'b0, a_in} + {1'b0, b_in} + cin_ext;
      3'd3: begin sum = {1'b0, a_in} - {1'b0, b_in} - cin_ext; is_sub = 1'b1; end
      3'd4: begin sum = {1'b0, a_in & b_in}; is_logic = 1'b1; end
      3'd6: begin sum = {1'b0, a_in ^ b_in}; is_logic = 1'b1; end
      default: begin sum = {1'b0, a_in} - {1'b0, b_in}; is_sub = 1'b1; end
    endcase
    ar_res = sum[WIDTH-1:0] & mask_in;
    a_msb  = |(a_in & msbm_in);
    b_msb  = |(b_in & msbm_in);
    r_msb  = |(ar_res & msbm_in);
    ar_cf  = |(sum[WIDTH:1] & msbm_in);
    ar_af  = ar_res[4] ^ a_in[4] ^ b_in[4];
    if (is_sub) begin
      ar_of = (a_msb != b_msb) && (r_msb != a_msb);
    end else begin
      ar_of = (a_msb == b_msb) && (r_msb != a_msb);
    end
    if (is_logic) begin
      ar_cf = 1'b0;
      ar_af = 1'b0;
      ar_of = 1'b0;
    end
    ar_flags     = flags;
    ar_flags[0]  = ar_cf;
    ar_flags[2]  = ~^ar_res[7:0];
    ar_flags[4]  = ar_af;
    ar_flags[6]  = (ar_res == '0);
    ar_flags[7]  = r_msb;
    ar_flags[11] = ar_of;
  end

  // One bit of shift/rotate. Right-moving ops insert at the sized MSB via the
  // latched one-hot; left-moving ops drop anything that crosses the size.
  always_comb begin
    shl_val  = (val_r << 1) & mask_r;
    shr_val  = val_r >> 1;
    v_msb    = |(val_r & msbm_r);
    v_lsb    = val_r[0];
    step_val = shl_val;
    step_cf  = v_msb;
    case (op_r)
      3'd0: step_val = shl_val | {{(WIDTH-1){1'b0}}, v_msb};
      3'd1: begin step_val = shr_val | (v_lsb ? msbm_r : '0); step_cf = v_lsb; end
      3'd2: step_val = shl_val | {{(WIDTH-1){1'b0}}, cf_r};
      3'd3: begin step_val = shr_val | (cf_r ? msbm_r : '0); step_cf = v_lsb; end
      3'd5: begin step_val = shr_val; step_cf = v_lsb; end
      3'd7: begin step_val = shr_val | (v_msb ? msbm_r : '0); step_cf = v_lsb; end
      default: ;
    endcase
  end

  // Flags for the final shift step. Rotates (op_r[2]=0) touch only CF/OF.
  always_comb begin
    s_msb  = |(step_val & msbm_r);
    s_msb1 = |(step_val & (msbm_r >> 1));
    case (op_r)
      3'd0:          sh_of = step_cf ^ s_msb;
      3'd1, 3'd3:    sh_of = s_msb ^ s_msb1;
      3'd5:          sh_of = msb0_r;
      3'd7:          sh_of = 1'b0;
      default:       sh_of = s_msb ^ step_cf;
    endcase
    sh_flags     = flags_r;
    sh_flags[0]  = step_cf;
    sh_flags[11] = sh_of;
    if (op_r[2]) begin
      sh_flags[2] = ~^step_val[7:0];
      sh_flags[4] = 1'b0;
      sh_flags[6] = (step_val == '0);
      sh_flags[7] = s_msb;
    end
  end

  // Next-state logic: only nonzero-count shifts pass through SHIFT.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (alu[3] && (count[4:0] != 5'd0)) ? SHIFT : DONE;
      SHIFT:   if (cnt == 5'd1) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Working registers are loaded on accept and stepped while shifting; the
  // visible outputs only change on the edge that enters DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      op_r      <= '0;
      mask_r    <= '0;
      msbm_r    <= '0;
      val_r     <= '0;
      cf_r      <= 1'b0;
      msb0_r    <= 1'b0;
      flags_r   <= '0;
      result    <= '0;
      flags_out <= '0;
      write     <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= count[4:0];
        op_r    <= alu[2:0];
        mask_r  <= mask_in;
        msbm_r  <= msbm_in;
        val_r   <= op1 & mask_in;
        cf_r    <= flags[0];
        msb0_r  <= |(op1 & msbm_in);
        flags_r <= flags;
      end else if (state == SHIFT) begin
        val_r <= step_val;
        cf_r  <= step_cf;
        cnt   <= cnt - 5'd1;
      end

      if (accept && !alu[3]) begin
        result    <= ar_res;
        flags_out <= ar_flags;
        write     <= (alu[2:0] != 3'd7);
      end else if (accept && (count[4:0] == 5'd0)) begin
        result    <= op1 & mask_in;
        flags_out <= flags;
        write     <= 1'b0;
      end else if ((state == SHIFT) && (cnt == 5'd1)) begin
        result    <= step_val;
        flags_out <= sh_flags;
        write     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq
//   Scoreboard bench for alu_seq at WIDTH=32. Each issued operation pushes
//   its expected result, flags, write and done cycle; a monitor pops and
//   compares whenever done is seen. Expectations come from a reference model
//   using plain integer arithmetic and closed-form rotates/shifts.

module tb_alu_seq;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    alu = '0;
  logic [1:0]    size = '0;
  logic [W-1:0]  op1 = '0;
  logic [W-1:0]  op2 = '0;
  logic [7:0]    count = '0;
  logic [11:0]   flags = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic [11:0]   flags_out;
  logic          write;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [11:0] fl;
    logic        wr;
    int          lat;
    int          dcyc;
  } exp_t;

  exp_t sbq[$];

  alu_seq #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .alu       (alu),
    .size      (size),
    .op1       (op1),
    .op2       (op2),
    .count     (count),
    .flags     (flags),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .flags_out (flags_out),
    .write     (write)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc = cyc + 1;

  // Signed view of a sized value.
  function automatic longint sx(input longint unsigned v, input int bits);
    if (((v >> (bits - 1)) & 64'd1) != 0) return $signed(v) - (longint'(1) << bits);
    return $signed(v);
  endfunction

  // Reference model: what the ALU should report for one request.
  function automatic exp_t model(input logic [3:0] op, input logic [1:0] sz,
                                 input logic [31:0] x, input logic [31:0] y,
                                 input logic [7:0] c, input logic [11:0] fl);
    exp_t e;
    int bits, n, k;
    longint unsigned m, m2, a, b, r, t;
    longint sa, sr, maxv, minv;
    bit cin, cf, of, af, msb, msb1;
    bits = (sz == 2'd0) ? 8 : (sz == 2'd2) ? 32 : 16;
    m    = (64'd1 << bits) - 1;
    a    = x & m;
    b    = y & m;
    n    = int'(c[4:0]);
    maxv = (longint'(1) << (bits - 1)) - 1;
    minv = -(longint'(1) << (bits - 1));
    e.fl = fl;
    e.wr = 1'b1;
    e.lat = 1;
    e.dcyc = 0;
    cf = 1'b0; of = 1'b0; af = 1'b0; r = 0;
    if (op < 4'd8) begin
      case (op)
        4'd0, 4'd2: begin
          cin = (op == 4'd2) ? fl[0] : 1'b0;
          r   = a + b + cin;
          cf  = (r > m);
          af  = ((a & 15) + (b & 15) + cin) > 15;
          sr  = sx(a, bits) + sx(b, bits) + cin;
          of  = (sr > maxv) || (sr < minv);
        end
        4'd3, 4'd5, 4'd7: begin
          cin = (op == 4'd3) ? fl[0] : 1'b0;
          r   = a - b - cin;
          cf  = (a < b + cin);
          af  = (a & 15) < ((b & 15) + cin);
          sr  = sx(a, bits) - sx(b, bits) - cin;
          of  = (sr > maxv) || (sr < minv);
        end
        4'd1:    r = a | b;
        4'd4:    r = a & b;
        default: r = a ^ b;
      endcase
      r = r & m;
      e.wr     = (op != 4'd7);
      e.fl[0]  = cf;
      e.fl[2]  = ~^r[7:0];
      e.fl[4]  = af;
      e.fl[6]  = (r == 0);
      e.fl[7]  = r[bits - 1];
      e.fl[11] = of;
    end else if (n == 0) begin
      r    = a;
      e.wr = 1'b0;
    end else begin
      e.lat = n + 1;
      m2 = (m << 1) | 1;
      t  = (64'(fl[0]) << bits) | a;
      case (op)
        4'd8: begin
          k  = n % bits;
          r  = ((a << k) | (a >> (bits - k))) & m;
          cf = r[0];
        end
        4'd9: begin
          k  = n % bits;
          r  = ((a >> k) | (a << (bits - k))) & m;
          cf = r[bits - 1];
        end
        4'd10: begin
          k  = n % (bits + 1);
          t  = ((t << k) | (t >> (bits + 1 - k))) & m2;
          r  = t & m;
          cf = t[bits];
        end
        4'd11: begin
          k  = n % (bits + 1);
          t  = ((t >> k) | (t << (bits + 1 - k))) & m2;
          r  = t & m;
          cf = t[bits];
        end
        4'd12, 4'd14: begin
          r  = (a << n) & m;
          cf = (n <= bits) ? a[bits - n] : 1'b0;
        end
        4'd13: begin
          r  = a >> n;
          cf = a[n - 1];
        end
        default: begin
          sa = sx(a, bits);
          r  = $unsigned(sa >>> n) & m;
          cf = ((sa >>> (n - 1)) & 1) != 0;
        end
      endcase
      msb  = r[bits - 1];
      msb1 = r[bits - 2];
      case (op)
        4'd8:          of = cf ^ msb;
        4'd9, 4'd11:   of = msb ^ msb1;
        4'd13:         of = a[bits - 1];
        4'd15:         of = 1'b0;
        default:       of = msb ^ cf;
      endcase
      e.fl[0]  = cf;
      e.fl[11] = of;
      if (op >= 4'd12) begin
        e.fl[2] = ~^r[7:0];
        e.fl[4] = 1'b0;
        e.fl[6] = (r == 0);
        e.fl[7] = msb;
      end
    end
    e.res = r[31:0];
    return e;
  endfunction

  // Compare the presented outputs with one scoreboard entry.
  task automatic checkOutput(input exp_t e);
    checks++;
    if (result !== e.res[W-1:0]) begin
      errors++;
      $display("[TB] FAIL result: got %h expected %h", result, e.res[W-1:0]);
    end
    checks++;
    if (flags_out !== e.fl) begin
      errors++;
      $display("[TB] FAIL flags_out: got %h expected %h", flags_out, e.fl);
    end
    checks++;
    if (write !== e.wr) begin
      errors++;
      $display("[TB] FAIL write: got %b expected %b", write, e.wr);
    end
    checks++;
    if (cyc != e.dcyc) begin
      errors++;
      $display("[TB] FAIL done_cycle: got %0d expected %0d", cyc, e.dcyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clock) begin
    if ((reset_n === 1'b1) && (done === 1'b1)) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d expected no pending operation", cyc);
      end else begin
        checkOutput(sbq.pop_front());
      end
    end
  end

  // Issue one request, then scramble inputs (with stray starts) while busy.
  task automatic applyStimulus(input logic [3:0] op, input logic [1:0] sz,
                               input logic [31:0] x, input logic [31:0] y,
                               input logic [7:0] c, input logic [11:0] fl);
    exp_t e;
    bit seen;
    @(negedge clock);
    alu = op; size = sz; op1 = x; op2 = y; count = c; flags = fl; start = 1'b1;
    e = model(op, sz, x, y, c, fl);
    e.dcyc = cyc + e.lat;
    sbq.push_back(e);
    seen = 1'b0;
    for (int i = 0; (i < 40) && !seen; i++) begin
      @(negedge clock);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL busy: cycle %0d got %b expected 1", i + 1, busy);
      end
      if (done === 1'b1) seen = 1'b1;
      alu   = 4'($urandom);
      size  = 2'($urandom);
      op1   = W'($urandom);
      op2   = W'($urandom);
      count = 8'($urandom);
      flags = 12'($urandom);
      start = 1'($urandom_range(0, 1));
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: got no done within 40 cycles expected done at cycle %0d", e.dcyc);
    end
  endtask

  task automatic checkZero(input string name);
    checks++;
    if ((busy !== 1'b0) || (done !== 1'b0) || (write !== 1'b0) ||
        (result !== '0) || (flags_out !== '0)) begin
      errors++;
      $display("[TB] FAIL %s: got busy=%b done=%b write=%b result=%h flags_out=%h expected all zero",
               name, busy, done, write, result, flags_out);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] alu_seq scoreboard bench, WIDTH=%0d", W);
    @(negedge clock);
    checkZero("reset_state");
    reset_n = 1'b1;

    applyStimulus(4'h0, 2'd0, 32'h000000FF, 32'h00000001, 8'd0,   12'h000);
    applyStimulus(4'h5, 2'd1, 32'h00008000, 32'h00000001, 8'd0,   12'h000);
    applyStimulus(4'h7, 2'd1, 32'h00008000, 32'h00000001, 8'd0,   12'h000);
    applyStimulus(4'hB, 2'd0, 32'h00000001, 32'h00000000, 8'd9,   12'h000);
    applyStimulus(4'hB, 2'd0, 32'h00000001, 32'h00000000, 8'h21,  12'h000);
    applyStimulus(4'hD, 2'd1, 32'h5A5A1234, 32'h00000000, 8'h20,  12'hABC);
    applyStimulus(4'h2, 2'd2, 32'hFFFFFFFF, 32'h00000000, 8'd0,   12'h001);
    applyStimulus(4'h3, 2'd0, 32'hFFFF0000, 32'h12345600, 8'd0,   12'h001);
    applyStimulus(4'h8, 2'd2, 32'h80000001, 32'h00000000, 8'd1,   12'h000);
    applyStimulus(4'hC, 2'd1, 32'h00008001, 32'h00000000, 8'd3,   12'h000);

    // Abort a long SAR with reset mid-operation; no done may follow.
    @(negedge clock);
    alu = 4'hF; size = 2'd2; op1 = 32'h80000000; op2 = '0; count = 8'd31; flags = 12'h000;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 checkZero("reset_abort");
    sbq.delete();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);

    applyStimulus(4'hF, 2'd2, 32'h80000000, 32'h00000000, 8'd31, 12'h000);

    for (int i = 0; i < 150; i++) begin
      applyStimulus(4'($urandom), 2'($urandom), $urandom, $urandom,
                    ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12)),
                    12'($urandom));
    end

    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending: got %0d outstanding expected 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle integer ALU for the x86 core, successor to the single-step combinational ALU. It executes the same 16 operation codes at 8, 16 or 32-bit operand size, and iterates shifts and rotates by a count operand (CL or imm8) one bit per clock. It computes the full arithmetic flag set. It sits between the operand fetch stage and writeback and talks to the microcode sequencer through a start/busy/done handshake.

## Interface
- WIDTH, 16: datapath width; legal values 16 or 32.
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only when busy=0.
- alu  in  4  opcode: 0 ADD, 1 OR, 2 ADC, 3 SBB, 4 AND, 5 SUB, 6 XOR, 7 CMP, 8 ROL, 9 ROR, A RCL, B RCR, C/E SHL, D SHR, F SAR.
- size  in  2  operand size: 0 = 8-bit, 1 = 16-bit, 2 = 32-bit (legal only when WIDTH=32), 3 is reserved and treated as 16-bit.
- op1  in  WIDTH  first operand (shift source).
- op2  in  WIDTH  second operand (ignored for opcodes 8–F).
- count  in  8  shift/rotate count; only count[4:0] is used.
- flags  in  12  incoming FLAGS. CF=bit0, PF=2, AF=4, ZF=6, SF=7, OF=11.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result/flags_out valid.
- result  out  WIDTH  result, zero-extended above the operand size.
- flags_out  out  12  updated FLAGS.
- write  out  1  result to be written back; 0 for CMP and for count=0 shifts; valid with done.

## Operation
- All inputs are latched on an accepted start. Later input changes are ignored until done.
- Bits above the operand size in op1/op2 are ignored. MSB is bit 7, 15 or 31 according to size.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> DONE when start is accepted and the op is 0–7, or the op is 8–F with count[4:0]=0.
  - IDLE -> SHIFT when start is accepted, the op is 8–F, and count[4:0]≠0. A down-counter is loaded with count[4:0].
  - SHIFT: one bit position per cycle, with CF updated each step. Decrement the counter; go to DONE when it reaches 1.
  - DONE: assert done for one cycle, return to IDLE.
- Arithmetic (0–7): computed in one step at the operand size.
  - ADC/SBB use the latched CF.
  - CF = carry/borrow out of MSB.
  - AF = carry/borrow out of bit 3.
  - OF = signed overflow.
  - ZF, SF, PF are taken from the sized result. PF = even parity of result[7:0].
  - CMP produces the SUB result and flags with write=0.
- Logic ops (OR/AND/XOR): CF=OF=AF=0; ZF, SF, PF from the result.
- Rotates (8–B): only CF and OF change. RCL/RCR rotate through CF over size+1 bits.
- Shifts (C–F): CF, ZF, SF, PF, OF updated; AF=0.
- OF is evaluated from the final state for any nonzero count:
  - ROL: OF = CF ^ MSB.
  - ROR and RCR: OF = MSB ^ (MSB-1).
  - RCL and SHL: OF = MSB ^ CF.
  - SHR: OF = original MSB.
  - SAR: OF = 0.
- Count 0 (after masking): result=op1, flags_out=flags, write=0.
- Flag bits not listed above pass through from the latched flags.

## Timing
- Reset values: busy=0, done=0, write=0, result=0, flags_out=0; FSM in IDLE. Reset mid-operation aborts immediately and produces no done.
- A start accepted in cycle 0 gives:
  - ops 0–7 and count-0 shifts: done in cycle 1;
  - shifts with N = count[4:0] ≥ 1: done in cycle N+1.
- busy=1 from the cycle after the accepted start through the done cycle inclusive.
- start while busy=1 is ignored. A new start is accepted in the cycle after done.
- result, flags_out and write are registered. They hold their values after done until the next done.

## Test plan
- 8-bit ADD, op1=0xFF, op2=0x01 -> done at cycle 1; result=0x00, CF=1, ZF=1, AF=1, PF=1, SF=0, OF=0, write=1.
- 16-bit SUB, op1=0x8000, op2=0x0001 -> result=0x7FFF, OF=1, CF=0, SF=0, AF=1, PF=1, ZF=0. Repeat as CMP: same flags, write=0.
- 16-bit SHL, op1=0x8001, count=3 -> done at cycle 4, busy high in cycles 1–4; result=0x0008, CF=0, ZF=0, PF=0.
- 8-bit RCR, op1=0x01, CF=0, count=9 -> result=0x01, CF=0, done at cycle 10. Same op with count=0x21 -> behaves as count=1: result=0x00, CF=1.
- Shift with count=0x20 -> done at cycle 1, result=op1, flags_out=flags, write=0. A start pulse while busy is ignored.
- 32-bit SAR (WIDTH=32), op1=0x80000000, count=31, with reset_n pulsed low at cycle 10 -> outputs zero immediately, no done. After release, the rerun gives result=0xFFFFFFFF, CF=0, SF=1, OF=0.
